// File: rtl/uart_rx_path_if.sv
// Serial-line side of the 8N1 receiver: rx pin in, byte/strobe/status out.
// master = receiver, slave = consumer (or bench) driving the pin.
interface uart_rx_path_if;
  logic       uart_rx_i;
  logic [7:0] uart_rx_data_o;
  logic       uart_rx_valid_o;
  logic       uart_rx_ferr_o;
  logic       uart_busy_o;

  modport master (
    input  uart_rx_i,
    output uart_rx_data_o, uart_rx_valid_o, uart_rx_ferr_o, uart_busy_o
  );

  modport slave (
    output uart_rx_i,
    input  uart_rx_data_o, uart_rx_valid_o, uart_rx_ferr_o, uart_busy_o
  );
endinterface

// File: rtl/uart_rx_path.sv
// 8N1 UART receiver, mid-bit sampling, LSB first, framing-error strobe.
// Optional UART_RX_MAJORITY_EN: 3-sample majority vote, decisions one cycle later.
module uart_rx_path #(
  parameter logic [13:0] BAUD_DIV = 14'd10416
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  uart_rx_path_if.master rx
);

  localparam logic [13:0] HALF = BAUD_DIV >> 1;
`ifdef UART_RX_MAJORITY_EN
  // Deciding one cycle late shifts DATA/STOP entry too, so only START moves.
  localparam logic [13:0] START_AT = HALF;
`else
  localparam logic [13:0] START_AT = HALF - 14'd1;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_nx;
  logic [1:0]  sync;
  logic        rx_s, rx_d;
  logic [13:0] cnt, cnt_nx;
  logic [2:0]  bit_idx, bit_idx_nx;
  logic [7:0]  shreg, shreg_nx;
  logic [7:0]  data_q, data_nx;
  logic        valid_q, valid_nx;
  logic        ferr_q, ferr_nx;
  logic        samp;

  assign rx_s = sync[1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync <= 2'b11;
      rx_d <= 1'b1;
    end else begin
      sync <= {sync[0], rx.uart_rx_i};
      rx_d <= rx_s;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) hist <= 2'b11;
    else          hist <= {hist[0], rx_s};
  end

  assign samp = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign samp = rx_s;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_idx_nx;
      shreg   <= shreg_nx;
      data_q  <= data_nx;
      valid_q <= valid_nx;
      ferr_q  <= ferr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    data_nx    = data_q;
    valid_nx   = 1'b0;
    ferr_nx    = 1'b0;
    // Wrap at BAUD_DIV so each data/stop sample lands one bit period later.
    if (state != IDLE) cnt_nx = (cnt == BAUD_DIV) ? '0 : cnt + 14'd1;
    case (state)
      IDLE: begin
        if (!rx_s && rx_d) begin
          state_nx = START;
          cnt_nx   = '0;
        end
      end
      START: begin
        if (cnt == START_AT) begin
          cnt_nx = '0;
          if (!samp) begin
            state_nx   = DATA;
            bit_idx_nx = '0;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt == BAUD_DIV) begin
          shreg_nx   = {samp, shreg[7:1]};
          bit_idx_nx = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (cnt == BAUD_DIV) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          if (samp) begin
            data_nx  = shreg;
            valid_nx = 1'b1;
          end else begin
            ferr_nx  = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign rx.uart_rx_data_o  = data_q;
  assign rx.uart_rx_valid_o = valid_q;
  assign rx.uart_rx_ferr_o  = ferr_q;
  assign rx.uart_busy_o     = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_path.sv
// Directed bench for uart_rx_path (BAUD_DIV=15): per-cycle model compare plus literal checks.
`timescale 1ns/1ps
module tb_uart_rx_path;
  localparam int P = 16;
  localparam int H = 7;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;
  uart_rx_path_if rx_if();

  uart_rx_path #(.BAUD_DIV(14'd15)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .rx      (rx_if)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Model: rx_s is the pin seen two cycles late; all sample points are
  // derived arithmetically from t0 (the falling edge seen while idle).
  logic       m_p1, m_p2, m_r1, m_r2, m_busy;
  int         t0;
  logic [7:0] m_bits;
  logic [7:0] nx_data;
  logic       nx_valid, nx_ferr, nx_busy;

  int         n_valid = 0, n_ferr = 0, n_busy_cyc = 0, last_valid_cyc = 0;
  logic [7:0] vq[$];

  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        m_p1 = 1'b1; m_p2 = 1'b1; m_r1 = 1'b1; m_r2 = 1'b1; m_busy = 1'b0;
        nx_data = 8'h00; nx_valid = 1'b0; nx_ferr = 1'b0; nx_busy = 1'b0;
      end
      check("data_o",  int'(rx_if.uart_rx_data_o),  int'(nx_data));
      check("valid_o", int'(rx_if.uart_rx_valid_o), int'(nx_valid));
      check("ferr_o",  int'(rx_if.uart_rx_ferr_o),  int'(nx_ferr));
      check("busy_o",  int'(rx_if.uart_busy_o),     int'(nx_busy));
      if (rx_if.uart_rx_valid_o) begin
        n_valid++;
        last_valid_cyc = cyc;
        vq.push_back(rx_if.uart_rx_data_o);
      end
      if (rx_if.uart_rx_ferr_o) n_ferr++;
      if (rx_if.uart_busy_o) n_busy_cyc++;
      if (rst_n_i) begin
        logic rs, v;
        int   rel, k;
        rs = m_p2;
        nx_valid = 1'b0;
        nx_ferr  = 1'b0;
        if (!m_busy) begin
          if (!rs && m_r1) begin
            m_busy = 1'b1;
            t0 = cyc;
          end
        end else begin
          rel = cyc - t0 - H - MAJ;
          v   = (MAJ != 0) ? maj3(m_r2, m_r1, rs) : rs;
          if (rel == 0) begin
            if (v) m_busy = 1'b0;
          end else if (rel > 0 && rel % P == 0) begin
            k = rel / P - 1;
            if (k < 8) m_bits[k] = v;
            else begin
              m_busy = 1'b0;
              if (v) begin nx_valid = 1'b1; nx_data = m_bits; end
              else nx_ferr = 1'b1;
            end
          end
        end
        nx_busy = m_busy;
        m_r2 = m_r1; m_r1 = rs;
        m_p2 = m_p1; m_p1 = rx_if.uart_rx_i;
      end
    end
  end

  task automatic hold(input logic lv, input int n);
    rx_if.uart_rx_i = lv;
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  // Drives ncyc cycles of a frame; 'flip' inverts the pin for one cycle.
  task automatic send(input logic [7:0] d, input logic stop, input int flip, input int ncyc);
    logic [9:0] fr;
    logic       lv;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < ncyc; i++) begin
      lv = fr[i / P];
      if (i == flip) lv = ~lv;
      rx_if.uart_rx_i = lv;
      @(posedge clk_i); #1;
    end
  endtask

  int v0, f0, b0, fall;

  initial begin
    rx_if.uart_rx_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_data",  int'(rx_if.uart_rx_data_o), 0);
    check("rst_valid", int'(rx_if.uart_rx_valid_o), 0);
    check("rst_busy",  int'(rx_if.uart_busy_o), 0);
    rst_n_i = 1'b1;
    hold(1'b1, 20);

    // Single frame: latency 2 (sync) + H + 9P + 1 from the pin edge
    v0 = n_valid; f0 = n_ferr; fall = cyc;
    send(8'h55, 1'b1, -1, 10 * P);
    hold(1'b1, 20);
    check("x55_pulses",  n_valid - v0, 1);
    check("x55_latency", last_valid_cyc - fall, 154 + MAJ);
    check("x55_data",    int'(rx_if.uart_rx_data_o), 8'h55);
    check("x55_noferr",  n_ferr - f0, 0);

    // Back-to-back frames with no idle gap
    vq.delete();
    send(8'hA3, 1'b1, -1, 10 * P);
    send(8'h00, 1'b1, -1, 10 * P);
    send(8'hFF, 1'b1, -1, 10 * P);
    hold(1'b1, 20);
    check("b2b_pulses", vq.size(), 3);
    if (vq.size() == 3) begin
      check("b2b_d0", int'(vq[0]), 8'hA3);
      check("b2b_d1", int'(vq[1]), 8'h00);
      check("b2b_d2", int'(vq[2]), 8'hFF);
    end

    // 4-cycle low glitch is rejected in START
    v0 = n_valid; f0 = n_ferr; b0 = n_busy_cyc;
    hold(1'b0, 4);
    hold(1'b1, 30);
    check("glitch_busy",   n_busy_cyc - b0, H + MAJ);
    check("glitch_pulses", (n_valid - v0) + (n_ferr - f0), 0);
    send(8'h3C, 1'b1, -1, 10 * P);
    hold(1'b1, 20);
    check("x3C_data", int'(rx_if.uart_rx_data_o), 8'h3C);

    // Framing error, then a held-low line must stay silent
    v0 = n_valid; f0 = n_ferr;
    send(8'h81, 1'b0, -1, 10 * P);
    hold(1'b0, 3 * P);
    hold(1'b1, 20);
    check("ferr_pulses", n_ferr - f0, 1);
    check("ferr_novalid", n_valid - v0, 0);
    check("ferr_keep",   int'(rx_if.uart_rx_data_o), 8'h3C);

    // Reset during data bit 4
    send(8'h66, 1'b1, -1, 5 * P + 5);
    rst_n_i = 1'b0;
    #1;
    check("mid_rst_data",  int'(rx_if.uart_rx_data_o), 0);
    check("mid_rst_busy",  int'(rx_if.uart_busy_o), 0);
    check("mid_rst_valid", int'(rx_if.uart_rx_valid_o), 0);
    hold(1'b1, 3);
    rst_n_i = 1'b1;
    hold(1'b1, 10);
    v0 = n_valid;
    send(8'h5A, 1'b1, -1, 10 * P);
    hold(1'b1, 20);
    check("x5A_pulses", n_valid - v0, 1);
    check("x5A_data",   int'(rx_if.uart_rx_data_o), 8'h5A);

    // One-cycle inversion at bit 2's nominal sample point
    send(8'h00, 1'b1, H + 3 * P, 10 * P);
    hold(1'b1, 20);
    check("flip_data", int'(rx_if.uart_rx_data_o), (MAJ != 0) ? 8'h00 : 8'h04);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
